// File: rtl/mem_arbiter.sv
// mem_arbiter: IFU/LSU round-robin arbiter onto one data-memory port, with timeout and misalignment errors
//   clk, rst                                   : clock, synchronous active-high reset
//   IfuReqValid/IfuAddr/IfuReqReady            : fetch request (always a word read)
//   IfuRespValid/IfuRdata                      : one-cycle fetch response
//   LsuReqValid/LsuWr/LsuAddr/LsuMemOp/LsuWdata: load/store request, LsuReqReady accepts it
//   LsuRespValid/LsuRdata                      : one-cycle LSU response (data 0 for stores)
//   MemReqValid/MemAddr/MemWr/MemOp/MemWdata   : request to memory, MemReqReady accepts it
//   MemRespValid/MemRdata                      : memory completion and read data
//   BusErr                                     : pulses with the response on timeout or misalignment
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IfuReqValid,
  input  logic [31:0] IfuAddr,
  output logic        IfuReqReady,
  output logic        IfuRespValid,
  output logic [31:0] IfuRdata,
  input  logic        LsuReqValid,
  input  logic        LsuWr,
  input  logic [31:0] LsuAddr,
  input  logic [2:0]  LsuMemOp,
  input  logic [31:0] LsuWdata,
  output logic        LsuReqReady,
  output logic        LsuRespValid,
  output logic [31:0] LsuRdata,
  output logic        MemReqValid,
  output logic [31:0] MemAddr,
  output logic        MemWr,
  output logic [2:0]  MemOp,
  output logic [31:0] MemWdata,
  input  logic        MemReqReady,
  input  logic        MemRespValid,
  input  logic [31:0] MemRdata,
  output logic        BusErr
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic last_lsu, owner_lsu, gnt_ifu, gnt_lsu, misal, done, tmo;
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // Misaligned LSU requests are answered from IDLE and never leave it
  always_comb begin
    state_nx = (state == IDLE)  ? ((gnt_ifu || (gnt_lsu && !misal)) ? ISSUE : IDLE) :
               (state == ISSUE) ? (MemReqReady ? WAIT : ISSUE) :
                                  ((done || tmo) ? IDLE : WAIT);
  end
  // On a tie the requester that did not win last time gets the port
  always_comb begin
    gnt_lsu = !rst && state == IDLE && LsuReqValid && (!IfuReqValid || !last_lsu);
    gnt_ifu = !rst && state == IDLE && IfuReqValid && !gnt_lsu;
    IfuReqReady = gnt_ifu;
    LsuReqReady = gnt_lsu;
    MemReqValid = !rst && state == ISSUE;
    misal = (LsuMemOp == 3'b010 && LsuAddr[1:0] != 2'b00) ||
            ((LsuMemOp == 3'b001 || LsuMemOp == 3'b101) && LsuAddr[0]);
    done = state == WAIT && MemRespValid;
    tmo = state == WAIT && !MemRespValid && cnt == CW'(TIMEOUT - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_lsu <= 1'b0;
      owner_lsu <= 1'b0;
      cnt <= '0;
      MemAddr <= '0;
      MemWr <= 1'b0;
      MemOp <= '0;
      MemWdata <= '0;
      IfuRespValid <= 1'b0;
      LsuRespValid <= 1'b0;
      IfuRdata <= '0;
      LsuRdata <= '0;
      BusErr <= 1'b0;
    end else begin
      if (gnt_ifu || gnt_lsu) begin
        last_lsu <= gnt_lsu;
        owner_lsu <= gnt_lsu;
        MemAddr <= gnt_lsu ? LsuAddr : IfuAddr;
        MemWr <= gnt_lsu && LsuWr;
        MemOp <= gnt_lsu ? LsuMemOp : 3'b010;
        MemWdata <= gnt_lsu ? LsuWdata : '0;
      end
      cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
      IfuRespValid <= (done || tmo) && !owner_lsu;
      LsuRespValid <= ((done || tmo) && owner_lsu) || (gnt_lsu && misal);
      IfuRdata <= (done && !owner_lsu) ? MemRdata : '0;
      LsuRdata <= (done && owner_lsu && !MemWr) ? MemRdata : '0;
      BusErr <= tmo || (gnt_lsu && misal);
    end
  end
endmodule
